// File: rtl/vx_tcu_uop_seq.sv
// Tensor-core micro-op sequencer: expands one whole-tile MMA instruction into
// M_STEPS x N_STEPS x K_STEPS micro-ops (n innermost, k outermost) on a valid/ready stream.
module vx_tcu_uop_seq #(
  parameter int M_STEPS = 2,
  parameter int N_STEPS = 2,
  parameter int K_STEPS = 2,
  parameter int A_SUB   = 2,
  parameter int B_SUB   = 2,
  parameter int META_W  = 64,
  parameter int RW      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [META_W-1:0] in_meta,
  input  logic [RW-1:0]     in_rd,
  input  logic [RW-1:0]     in_rs1,
  input  logic [RW-1:0]     in_rs2,
  input  logic [3:0]        in_fmt_s,
  input  logic [3:0]        in_fmt_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [META_W-1:0] out_meta,
  output logic [3:0]        out_step_m,
  output logic [3:0]        out_step_n,
  output logic [3:0]        out_step_k,
  output logic [RW-1:0]     out_rd,
  output logic [RW-1:0]     out_rs1,
  output logic [RW-1:0]     out_rs2,
  output logic [RW-1:0]     out_rs3,
  output logic [3:0]        out_fmt_s,
  output logic [3:0]        out_fmt_d,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic [3:0] M_LAST = 4'(M_STEPS - 1);
  localparam logic [3:0] N_LAST = 4'(N_STEPS - 1);
  localparam logic [3:0] K_LAST = 4'(K_STEPS - 1);
  localparam int A_SH = $clog2(A_SUB);
  localparam int B_SH = $clog2(B_SUB);

  state_e              state_q, state_d;
  logic [3:0]          m_q, m_d, n_q, n_d, k_q, k_d;
  logic [META_W-1:0]   meta_q, meta_d;
  logic [RW-1:0]       rd_base_q, rd_base_d;
  logic [RW-1:0]       rs1_base_q, rs1_base_d;
  logic [RW-1:0]       rs2_base_q, rs2_base_d;
  logic [3:0]          fmt_s_q, fmt_s_d, fmt_d_q, fmt_d_d;

  logic n_wrap, m_wrap, k_wrap, last_uop;

  // Accumulator D/C tiles are laid out m-major, one register per (m, n) sub-tile.
  function automatic logic [RW-1:0] rd_index(input logic [RW-1:0] base,
                                             input logic [3:0] m, input logic [3:0] n);
    logic [RW-1:0] off;
    off = RW'(m) * RW'(N_STEPS) + RW'(n);
    return base + off;
  endfunction

  // A operands pack A_SUB m-sub-blocks per register; each k step consumes M_STEPS/A_SUB registers.
  function automatic logic [RW-1:0] rs1_index(input logic [RW-1:0] base,
                                              input logic [3:0] k, input logic [3:0] m);
    logic [RW-1:0] off;
    off = RW'(k) * RW'(M_STEPS / A_SUB) + RW'(m >> A_SH);
    return base + off;
  endfunction

  function automatic logic [RW-1:0] rs2_index(input logic [RW-1:0] base,
                                              input logic [3:0] k, input logic [3:0] n);
    logic [RW-1:0] off;
    off = RW'(k) * RW'(N_STEPS / B_SUB) + RW'(n >> B_SH);
    return base + off;
  endfunction

  assign n_wrap   = (n_q == N_LAST);
  assign m_wrap   = (m_q == M_LAST);
  assign k_wrap   = (k_q == K_LAST);
  assign last_uop = n_wrap && m_wrap && k_wrap;

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    k_d        = k_q;
    meta_d     = meta_q;
    rd_base_d  = rd_base_q;
    rs1_base_d = rs1_base_q;
    rs2_base_d = rs2_base_q;
    fmt_s_d    = fmt_s_q;
    fmt_d_d    = fmt_d_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          meta_d     = in_meta;
          rd_base_d  = in_rd;
          rs1_base_d = in_rs1;
          rs2_base_d = in_rs2;
          fmt_s_d    = in_fmt_s;
          fmt_d_d    = in_fmt_d;
          m_d        = 4'd0;
          n_d        = 4'd0;
          k_d        = 4'd0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_uop) state_d = IDLE;
          // n innermost, carrying into m, then into k
          if (!n_wrap) begin
            n_d = n_q + 4'd1;
          end else begin
            n_d = 4'd0;
            if (!m_wrap) begin
              m_d = m_q + 4'd1;
            end else begin
              m_d = 4'd0;
              k_d = k_wrap ? 4'd0 : k_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      m_q        <= 4'd0;
      n_q        <= 4'd0;
      k_q        <= 4'd0;
      meta_q     <= '0;
      rd_base_q  <= '0;
      rs1_base_q <= '0;
      rs2_base_q <= '0;
      fmt_s_q    <= 4'd0;
      fmt_d_q    <= 4'd0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      k_q        <= k_d;
      meta_q     <= meta_d;
      rd_base_q  <= rd_base_d;
      rs1_base_q <= rs1_base_d;
      rs2_base_q <= rs2_base_d;
      fmt_s_q    <= fmt_s_d;
      fmt_d_q    <= fmt_d_d;
    end
  end

  assign busy       = (state_q == ISSUE);
  assign out_meta   = meta_q;
  assign out_step_m = m_q;
  assign out_step_n = n_q;
  assign out_step_k = k_q;
  assign out_rd     = rd_index(rd_base_q, m_q, n_q);
  assign out_rs3    = out_rd;
  assign out_rs1    = rs1_index(rs1_base_q, k_q, m_q);
  assign out_rs2    = rs2_index(rs2_base_q, k_q, n_q);
  assign out_fmt_s  = fmt_s_q;
  assign out_fmt_d  = fmt_d_q;
  assign out_sop    = busy && (m_q == 4'd0) && (n_q == 4'd0) && (k_q == 4'd0);
  assign out_eop    = busy && last_uop;

endmodule

// File: tb/tb_vx_tcu_uop_seq.sv
// Directed bench for vx_tcu_uop_seq: default 2x2x2 instance plus a 1x1x1 instance.
module tb_vx_tcu_uop_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_meta, out_meta;
  logic [5:0]  in_rd, in_rs1, in_rs2, out_rd, out_rs1, out_rs2, out_rs3;
  logic [3:0]  in_fmt_s, in_fmt_d, out_fmt_s, out_fmt_d;
  logic [3:0]  out_step_m, out_step_n, out_step_k;
  logic        out_sop, out_eop, busy;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [63:0] out_meta1;
  logic [5:0]  out_rd1, out_rs1_1, out_rs2_1, out_rs3_1;
  logic [3:0]  out_fmt_s1, out_fmt_d1, out_step_m1, out_step_n1, out_step_k1;
  logic        out_sop1, out_eop1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_tcu_uop_seq u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_meta(in_meta),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_meta(out_meta),
    .out_step_m(out_step_m), .out_step_n(out_step_n), .out_step_k(out_step_k),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
  );

  vx_tcu_uop_seq #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1), .A_SUB(1), .B_SUB(1)) u_one (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_meta(in_meta),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_meta(out_meta1),
    .out_step_m(out_step_m1), .out_step_n(out_step_n1), .out_step_k(out_step_k1),
    .out_rd(out_rd1), .out_rs1(out_rs1_1), .out_rs2(out_rs2_1), .out_rs3(out_rs3_1),
    .out_fmt_s(out_fmt_s1), .out_fmt_d(out_fmt_d1),
    .out_sop(out_sop1), .out_eop(out_eop1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected fields of micro-op i (k,m,n = bits 2,1,0) for the 2x2x2, A_SUB=B_SUB=2 instance.
  task automatic check_op(input string tag, input int i, input logic [5:0] rdb,
                          input logic [5:0] rs1b, input logic [5:0] rs2b, input logic [63:0] meta);
    int k, m, n;
    logic [5:0] erd, ers1, ers2;
    k = i / 4;
    m = (i / 2) % 2;
    n = i % 2;
    erd  = rdb + 6'(m * 2 + n);
    ers1 = rs1b + 6'(k);
    ers2 = rs2b + 6'(k);
    check($sformatf("%s_op%0d_valid", tag, i), 64'(out_valid), 64'd1);
    check($sformatf("%s_op%0d_k", tag, i), 64'(out_step_k), 64'(k));
    check($sformatf("%s_op%0d_m", tag, i), 64'(out_step_m), 64'(m));
    check($sformatf("%s_op%0d_n", tag, i), 64'(out_step_n), 64'(n));
    check($sformatf("%s_op%0d_rd", tag, i), 64'(out_rd), 64'(erd));
    check($sformatf("%s_op%0d_rs3", tag, i), 64'(out_rs3), 64'(erd));
    check($sformatf("%s_op%0d_rs1", tag, i), 64'(out_rs1), 64'(ers1));
    check($sformatf("%s_op%0d_rs2", tag, i), 64'(out_rs2), 64'(ers2));
    check($sformatf("%s_op%0d_sop", tag, i), 64'(out_sop), 64'(i == 0));
    check($sformatf("%s_op%0d_eop", tag, i), 64'(out_eop), 64'(i == 7));
    check($sformatf("%s_op%0d_meta", tag, i), out_meta, meta);
    check($sformatf("%s_op%0d_in_ready", tag, i), 64'(in_ready), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    in_valid = 1'b0;
    in_valid1 = 1'b0;
    out_ready = 1'b1;
    out_ready1 = 1'b1;
    in_meta = 64'd0;
    in_rd = 6'd0;
    in_rs1 = 6'd0;
    in_rs2 = 6'd0;
    in_fmt_s = 4'd0;
    in_fmt_d = 4'd0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    check_idle("rst");
    check("rst_sop", 64'(out_sop), 64'd0);
    check("rst_eop", 64'(out_eop), 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);
    check("rst_meta", out_meta, 64'd0);
    check("rst_step_k", 64'(out_step_k), 64'd0);
    check("rst_one_in_ready", 64'(in_ready1), 64'd1);

    // Basic expansion
    in_valid = 1'b1;
    in_meta = 64'hA000_0000_0000_00A1;
    in_rd = 6'd8;
    in_rs1 = 6'd2;
    in_rs2 = 6'd4;
    in_fmt_s = 4'd3;
    in_fmt_d = 4'd5;
    tick();
    in_valid = 1'b0;
    in_meta = 64'd0;
    check("basic_fmt_s", 64'(out_fmt_s), 64'd3);
    check("basic_fmt_d", 64'(out_fmt_d), 64'd5);
    for (int i = 0; i < 8; i++) begin
      check_op("basic", i, 6'd8, 6'd2, 6'd4, 64'hA000_0000_0000_00A1);
      tick();
    end
    check_idle("basic_end");

    // Back-pressure at micro-op 3
    in_valid = 1'b1;
    in_meta = 64'h0000_0000_0000_00B2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_op("bp", i, 6'd8, 6'd2, 6'd4, 64'h0000_0000_0000_00B2);
      tick();
    end
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check_op($sformatf("bp_stall%0d", s), 3, 6'd8, 6'd2, 6'd4, 64'h0000_0000_0000_00B2);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      check_op("bp", i, 6'd8, 6'd2, 6'd4, 64'h0000_0000_0000_00B2);
      tick();
    end
    check_idle("bp_end");

    // Back-to-back with in_valid held; second instruction also checks register wrap
    in_valid = 1'b1;
    in_meta = 64'h0000_0000_0000_00C3;
    tick();
    in_meta = 64'h0000_0000_0000_00D4;
    in_rd = 6'd62;
    in_rs1 = 6'd63;
    for (int i = 0; i < 8; i++) begin
      check_op("b2b_first", i, 6'd8, 6'd2, 6'd4, 64'h0000_0000_0000_00C3);
      tick();
    end
    check_idle("b2b_gap");
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_op("b2b_wrap", i, 6'd62, 6'd63, 6'd4, 64'h0000_0000_0000_00D4);
      tick();
    end
    check_idle("b2b_end");

    // Reset mid-instruction
    in_valid = 1'b1;
    in_meta = 64'h0000_0000_0000_00E5;
    in_rd = 6'd8;
    in_rs1 = 6'd2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_op("rstmid", i, 6'd8, 6'd2, 6'd4, 64'h0000_0000_0000_00E5);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("rstmid_after");
    check("rstmid_sop", 64'(out_sop), 64'd0);
    in_valid = 1'b1;
    in_meta = 64'h0000_0000_0000_00F6;
    tick();
    in_valid = 1'b0;
    check_op("restart", 0, 6'd8, 6'd2, 6'd4, 64'h0000_0000_0000_00F6);
    cyc = 0;
    while (!(out_valid && out_eop) && cyc < 20) begin
      tick();
      cyc++;
    end
    check("restart_drain_eop", 64'(out_valid && out_eop), 64'd1);
    check("restart_drain_len", 64'(cyc), 64'd7);
    tick();
    check_idle("restart_end");

    // Degenerate 1x1x1 instance
    in_valid1 = 1'b1;
    in_meta = 64'h0000_0000_0000_0017;
    in_rd = 6'd20;
    in_rs1 = 6'd30;
    in_rs2 = 6'd40;
    tick();
    in_valid1 = 1'b0;
    check("one_valid", 64'(out_valid1), 64'd1);
    check("one_sop", 64'(out_sop1), 64'd1);
    check("one_eop", 64'(out_eop1), 64'd1);
    check("one_rd", 64'(out_rd1), 64'd20);
    check("one_rs1", 64'(out_rs1_1), 64'd30);
    check("one_rs2", 64'(out_rs2_1), 64'd40);
    check("one_meta", out_meta1, 64'h17);
    check("one_busy", 64'(busy1), 64'd1);
    tick();
    check("one_end_in_ready", 64'(in_ready1), 64'd1);
    check("one_end_valid", 64'(out_valid1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_tcu_uop_seq.md
# vx_tcu_uop_seq

Micro-op sequencer directly upstream of the tensor-core FP datapath. Accepts one whole-tile MMA instruction from dispatch and expands it into M_STEPS×N_STEPS×K_STEPS micro-ops. Each micro-op carries step_m/step_n/step_k, computed register indices and sop/eop, and is presented on a valid/ready stream that feeds the FEDP execute interface. The block buffers exactly one instruction and stalls cleanly under downstream back-pressure.

## Interface
- M_STEPS, default 2: m sub-tiles per instruction (power of two, 1..16).
- N_STEPS, default 2: n sub-tiles per instruction (power of two, 1..16).
- K_STEPS, default 2: k sub-tiles per instruction (power of two, 1..16).
- A_SUB, default 2: A sub-blocks packed per source register (power of two, ≤ M_STEPS).
- B_SUB, default 2: B sub-blocks packed per source register (power of two, ≤ N_STEPS).
- META_W, default 64: opaque metadata width (uuid, wid, PC), passed through untouched.
- RW, default 6: register index width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction.
- in_meta  in  META_W  instruction metadata.
- in_rd, in_rs1, in_rs2  in  RW each  base registers for D/C, A, B.
- in_fmt_s, in_fmt_d  in  4 each  source/destination formats.
- out_valid  out  1  micro-op valid.
- out_ready  in  1  downstream accepts micro-op.
- out_meta  out  META_W  latched in_meta.
- out_step_m, out_step_n, out_step_k  out  4 each  current step indices.
- out_rd, out_rs1, out_rs2, out_rs3  out  RW each  micro-op register indices.
- out_fmt_s, out_fmt_d  out  4 each  latched formats.
- out_sop, out_eop  out  1 each  first / last micro-op of instruction.
- busy  out  1  instruction in flight.

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: in_ready=1, out_valid=0. On in_valid: latch meta, bases and formats; clear m/n/k counters; go to ISSUE.
- ISSUE: out_valid=1, in_ready=0. On out_valid&&out_ready, advance counters. n is innermost, then m, then k outermost.
- n wraps at N_STEPS-1 and carries to m. m wraps at M_STEPS-1 and carries to k.
- Fire at m=M_STEPS-1, n=N_STEPS-1, k=K_STEPS-1 returns the FSM to IDLE.
- Register index rules (modulo 2^RW, wrap silently):
  - out_rd = out_rs3 = in_rd + m·N_STEPS + n (in-place accumulate).
  - out_rs1 = in_rs1 + k·(M_STEPS/A_SUB) + m/A_SUB.
  - out_rs2 = in_rs2 + k·(N_STEPS/B_SUB) + n/B_SUB.
- step_m, step_n and step_k carry the raw m, n and k counters. The downstream stage masks step_m and step_n with its sub-block count.
- out_sop=1 only when m=n=k=0. out_eop=1 only on the final micro-op. Both are 1 on the same micro-op when M=N=K=1.
- busy = (state==ISSUE).
- Read-after-write ordering between k iterations on the same rd is the scoreboard's job, not this block's.

## Timing
- Reset: state=IDLE, counters=0, out_valid=0, in_ready=1, busy=0, out_sop=out_eop=0. All other outputs are 0.
- Reset asserted mid-instruction: remaining micro-ops are dropped. out_valid=0 on the cycle after the reset edge.
- Acceptance to first micro-op latency: 1 cycle (registered outputs).
- Throughput: one micro-op per cycle while out_ready=1. An instruction occupies M·N·K+1 cycles, including one IDLE cycle before the next accept.
- Stall (out_ready=0): out_valid stays 1 and every out_* field holds stable until the fire.
- in_valid while busy: ignored (in_ready=0). Dispatch must hold its request.
- in_ready is combinational from state only, never from out_ready.

## Test plan
- Basic expansion, M=N=K=2, A_SUB=B_SUB=2, in_rd=8, in_rs1=2, in_rs2=4, out_ready=1 -> 8 micro-ops on consecutive cycles.
  - (k,m,n) order: 000,001,010,011,100,101,110,111.
  - rd sequence: 8,9,10,11,8,9,10,11.
  - rs1: 2 for k=0, 3 for k=1. rs2: 4 for k=0, 5 for k=1.
  - sop on op 0 only, eop on op 7 only.
- Back-pressure: deassert out_ready for 3 cycles at micro-op 3 -> fields stay (k=0,m=1,n=1,rd=11) for 4 cycles, with no skipped or duplicated micro-op.
- Back-to-back instructions, in_valid held high -> second instruction accepted on the cycle after the first one's eop fire.
  - Its first micro-op appears one cycle later, carrying the new meta.
- Degenerate case M=N=K=1 -> a single micro-op with sop=eop=1, then in_ready=1 on the next cycle.
- Reset mid-op: assert reset after micro-op 2 fires -> out_valid=0 next cycle.
  - A new instruction then starts at sop with k=m=n=0.
- Register wrap, RW=6, in_rd=62, M=N=K=2 -> rd sequence 62,63,0,1.
